// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, shared sample prescaler, per-button debounce, press/release pulses.
// Optional auto-repeat of the press pulse while a button is held, enabled by defining BTN_REPEAT_EN.
module btn_conditioner #(
    parameter int NBTN   = 4,
    parameter int DIVW   = 20,
    parameter int STABLE = 4,
    parameter int REPDLY = 64,
    parameter int REPINT = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NBTN-1:0] BTN,
    output logic [NBTN-1:0] BTNLVL,
    output logic [NBTN-1:0] BTNPRESS,
    output logic [NBTN-1:0] BTNREL,
    output logic            TICK
);
    localparam logic [3:0]      STB_LAST = 4'(STABLE - 1);
    localparam logic [DIVW-1:0] DIV_ONE  = DIVW'(1'b1);
    localparam bit CFG_OK = (STABLE >= 2) && (STABLE <= 15) && (REPDLY > REPINT) &&
                            (REPINT >= 1) && (REPDLY <= 255);

    // Illegal parameter sets elaborate this marker block so a checker can key on it.
    if (!CFG_OK) begin : g_illegal_cfg
    end

    logic [NBTN-1:0] sync1_r;
    logic [NBTN-1:0] sync2_r;
    logic [DIVW-1:0] div_r;
    logic            tick_r;
    logic [3:0]      cnt_r [NBTN];
    logic [3:0]      cnt_s [NBTN];
    logic [NBTN-1:0] lvl_s;
    logic [NBTN-1:0] rise_s;
    logic [NBTN-1:0] fall_s;
    logic [NBTN-1:0] press_s;

    assign TICK = tick_r;

    // Two-flop synchronizer for the asynchronous button pins.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_r <= {NBTN{1'b0}};
            sync2_r <= {NBTN{1'b0}};
        end else begin
            sync1_r <= BTN;
            sync2_r <= sync1_r;
        end
    end

    // Free-running prescaler; the strobe is high the cycle after the counter wraps from all-ones.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_r  <= {DIVW{1'b0}};
            tick_r <= 1'b0;
        end else begin
            div_r  <= div_r + DIV_ONE;
            tick_r <= &div_r;
        end
    end

    // Debounce next-state: a differing sample must survive STABLE consecutive ticks to flip the level.
    always_comb begin
        lvl_s  = BTNLVL;
        rise_s = {NBTN{1'b0}};
        fall_s = {NBTN{1'b0}};
        for (int i = 0; i < NBTN; i++) begin
            cnt_s[i] = cnt_r[i];
            if (tick_r) begin
                if (sync2_r[i] == BTNLVL[i]) begin
                    cnt_s[i] = 4'd0;
                end else if (cnt_r[i] < STB_LAST) begin
                    cnt_s[i] = cnt_r[i] + 4'd1;
                end else begin
                    cnt_s[i]  = 4'd0;
                    lvl_s[i]  = sync2_r[i];
                    rise_s[i] = sync2_r[i];
                    fall_s[i] = ~sync2_r[i];
                end
            end else begin
                cnt_s[i] = cnt_r[i];
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam logic [7:0] REP_DLY = 8'(REPDLY);
    localparam logic [7:0] REP_RLD = 8'(REPDLY - REPINT);

    logic [7:0]      rep_r [NBTN];
    logic [7:0]      rep_s [NBTN];
    logic [NBTN-1:0] rep_hit_s;

    // Repeat counter only runs on ticks where the level was already high, so the rise tick is not counted
    // and the falling tick clears it without a repeat pulse colliding with the release pulse.
    always_comb begin
        rep_hit_s = {NBTN{1'b0}};
        for (int i = 0; i < NBTN; i++) begin
            rep_s[i] = rep_r[i];
            if (!lvl_s[i]) begin
                rep_s[i] = 8'd0;
            end else if (tick_r && BTNLVL[i]) begin
                if (rep_r[i] == 8'hFF) begin
                    rep_s[i] = rep_r[i];
                end else if ((rep_r[i] + 8'd1) == REP_DLY) begin
                    rep_s[i]     = REP_RLD;
                    rep_hit_s[i] = 1'b1;
                end else begin
                    rep_s[i] = rep_r[i] + 8'd1;
                end
            end else begin
                rep_s[i] = rep_r[i];
            end
        end
        press_s = rise_s | rep_hit_s;
    end

    // Repeat counter state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NBTN; i++) begin
                rep_r[i] <= 8'd0;
            end
        end else begin
            rep_r <= rep_s;
        end
    end
`else
    // Without auto-repeat the press pulse is just the debounced rising edge.
    always_comb begin
        press_s = rise_s;
    end
`endif

    // Debounce counters, levels and edge pulses all update on the same edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NBTN; i++) begin
                cnt_r[i] <= 4'd0;
            end
            BTNLVL   <= {NBTN{1'b0}};
            BTNPRESS <= {NBTN{1'b0}};
            BTNREL   <= {NBTN{1'b0}};
        end else begin
            cnt_r    <= cnt_s;
            BTNLVL   <= lvl_s;
            BTNPRESS <= press_s;
            BTNREL   <= fall_s;
        end
    end
endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream input stage for the Zybo push buttons. Converts raw, asynchronous, bouncing button pins into clean levels and single-cycle event pulses.
- Its press pulse drives mode-change inputs directly, e.g. the blink direction/speed controllers. Those controllers consume BTNPRESS as their one-cycle "change mode" strobe.
- Handles NBTN buttons independently, with one shared sample prescaler.

Parameters:
- NBTN, 4: number of buttons handled (BTN width).
- DIVW, 20: prescaler width. A sample tick occurs every 2^DIVW clocks (about 8.4 ms at 125 MHz).
- STABLE, 4: consecutive ticks a new sample value must persist before the level flips. Legal range 2..15.
- REPDLY, 64: ticks a button must be held before auto-repeat starts. Used only with BTN_REPEAT_EN.
- REPINT, 16: ticks between auto-repeat pulses. Used only with BTN_REPEAT_EN.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-low reset. Low = reset.
- BTN  input  NBTN  raw button pins; asynchronous, bouncing.
- BTNLVL  output  NBTN  debounced level per button, registered.
- BTNPRESS  output  NBTN  one-cycle pulse on a debounced 0->1 transition (and on auto-repeat events when enabled).
- BTNREL  output  NBTN  one-cycle pulse on a debounced 1->0 transition.
- TICK  output  1  prescaler sample strobe, one cycle wide; exported for bench and neighbouring blocks.

Behaviour:
- Asynchronous reset (RST low):
  - Every flop clears immediately, without waiting for a clock edge: synchronizer, prescaler, per-button counters, BTNLVL, BTNPRESS, BTNREL, TICK, repeat counters.
  - After reset is released, the first state update occurs at the next CLK rising edge.
- Synchronizer: each BTN bit passes through 2 flops. The synchronizer output is called S below.
- Prescaler:
  - DIVW-bit counter, free-running from reset and never cleared by button activity.
  - TICK is registered and high for exactly the one cycle after the counter reaches all-ones. Period is exactly 2^DIVW cycles.
- Per-button debounce, with a 4-bit counter c. On each cycle where the tick is active:
  - S == BTNLVL: c <= 0.
  - S != BTNLVL and c < STABLE-1: c <= c+1.
  - S != BTNLVL and c == STABLE-1: BTNLVL <= S, c <= 0, and a pulse is raised.
  - On non-tick cycles c and BTNLVL hold.
- Pulses:
  - BTNPRESS or BTNREL is asserted on the same edge that updates BTNLVL, for exactly 1 cycle.
  - A single button never has PRESS and REL asserted together.
- Latency: a clean input edge is reflected on BTNLVL within 2 + (STABLE-1)*2^DIVW + 1 to 2 + STABLE*2^DIVW + 1 cycles.
- Glitch rejection: any sample run shorter than STABLE ticks resets c. No level change and no pulse.
- Buttons are fully independent. Simultaneous transitions on several buttons produce simultaneous pulses.
- Input held permanently at power-up:
  - The level starts at 0 after reset.
  - The pressed state is therefore reported as a press after the normal latency.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined: each button has a repeat counter r (8 bits, saturating), cleared whenever BTNLVL is 0.
  - While BTNLVL is 1, r increments on each tick.
  - When r reaches REPDLY, BTNPRESS pulses for 1 cycle and r reloads to REPDLY-REPINT.
  - This gives a pulse every REPINT ticks while the button is held.
  - The release edge clears r with no extra pulse.
  - Constraint: REPDLY > REPINT >= 1, REPDLY <= 255.
- Undefined: no repeat logic is synthesized and REPDLY/REPINT are ignored. BTNPRESS pulses exactly once per debounced press.

Test Plan:
- Reset values: hold RST=0 with BTN=4'hF for 100 cycles -> BTNLVL=0, BTNPRESS=0, BTNREL=0, TICK=0 throughout.
- Clean press (DIVW=4, STABLE=4): release reset, set BTN[0]=1 and hold -> exactly one BTNPRESS[0] pulse of 1 cycle.
  - The pulse falls within 51..66 cycles of the BTN change.
  - BTNLVL[0]=1 from the same edge; no other bits toggle.
- Bounce rejection: with BTNLVL[1]=0, toggle BTN[1] high for 40 cycles then low, repeated 5 times -> BTNLVL[1] stays 0 and BTNPRESS[1] never asserts.
- Release plus multi-button: with BTNLVL=4'b0011, drop BTN[0] and BTN[1] in the same cycle -> BTNREL=4'b0011 for exactly one cycle, then BTNLVL=0.
- Reset mid-count: press BTN[2]; after 2 ticks pull RST low for 3 cycles -> outputs clear asynchronously, before the next CLK edge.
  - After release, the full STABLE-tick latency restarts; it is not shortened.
- BTN_REPEAT_EN (DIVW=4, REPDLY=8, REPINT=2): hold BTN[3] for 20 ticks -> initial BTNPRESS[3].
  - Then a pulse at tick 8 after the level rise and every 2 ticks thereafter (6 repeat pulses).
  - No pulse on release.
